// File: rtl/tick_sched_pkg.sv
// ============================================================================
//  Module      : tick_sched_pkg
//  Description : Shared types, defaults and helpers for the tick scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

    localparam int DEF_NCH      = 4;
    localparam int DEF_PRESCALE = 50;
    localparam int DEF_DIV_W    = 8;

    // Index width for a given channel count (at least one bit).
    function automatic int calc_ch_w(input int nch);
        int w;
        w = 1;
        while ((1 << w) < nch) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_if.sv
// ============================================================================
//  Module      : tick_scheduler_if
//  Description : Valid/ready configuration port of the tick scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_scheduler_if
    import tick_sched_pkg::*;
#(
    parameter int CH_W  = 2,
    parameter int DIV_W = DEF_DIV_W
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );

endinterface

`default_nettype wire

// File: rtl/tick_channel.sv
// ============================================================================
//  Module      : tick_channel
//  Description : One divider channel: counts prescaler strobes, emits a
//                one-cycle tick and a toggling square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             pre_tick,
    input  wire logic             load,
    input  wire logic [DIV_W-1:0] load_div,
    input  wire logic             load_en,
    output logic                  tick,
    output logic                  sq
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q,  en_d;
    logic             tick_q, tick_d;
    logic             sq_q,  sq_d;

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        en_d   = en_q;
        tick_d = 1'b0;
        sq_d   = sq_q;

        // A load swallows the strobe it lands on, so no tick can leak out.
        if (load) begin
            div_d = load_div;
            en_d  = load_en;
            cnt_d = '0;
            if (!load_en) begin
                sq_d = 1'b0;
            end
        end else if (pre_tick && en_q && (div_q != '0)) begin
            if (cnt_q == (div_q - DIV_W'(1))) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q  <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
//  Module      : tick_scheduler
//  Description : Shared prescaler feeding NCH clock-enable channels, with a
//                valid/ready port that reprograms channels on strobe edges.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int CH_W     = calc_ch_w(NCH)
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    tick_scheduler_if.slave     cfg,
    output logic                pre_tick,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      sq,
    output logic                busy
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  count_q, count_d;
    logic             pre_tick_q, pre_tick_d;
    cfg_state_e       state_q, state_d;
    logic [CH_W-1:0]  lat_ch_q, lat_ch_d;
    logic [DIV_W-1:0] lat_div_q, lat_div_d;
    logic             lat_en_q, lat_en_d;
    logic             w_ready;
    logic             w_apply;
    logic [NCH-1:0]   w_load;

    always_comb begin
        pre_tick_d = (count_q == PS_W'(PRESCALE - 1));
        count_d    = pre_tick_d ? '0 : (count_q + PS_W'(1));
    end

    always_comb begin
        state_d   = state_q;
        lat_ch_d  = lat_ch_q;
        lat_div_d = lat_div_q;
        lat_en_d  = lat_en_q;
        w_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                w_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    lat_ch_d  = cfg.cfg_ch;
                    lat_div_d = cfg.cfg_div;
                    lat_en_d  = cfg.cfg_en;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (pre_tick_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_apply = (state_q == PEND) && pre_tick_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q    <= '0;
            pre_tick_q <= 1'b0;
            state_q    <= IDLE;
            lat_ch_q   <= '0;
            lat_div_q  <= '0;
            lat_en_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            pre_tick_q <= pre_tick_d;
            state_q    <= state_d;
            lat_ch_q   <= lat_ch_d;
            lat_div_q  <= lat_div_d;
            lat_en_q   <= lat_en_d;
        end
    end

    // Indices with no matching channel decode to nothing, dropping the write.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_load[i] = w_apply && (lat_ch_q == CH_W'(i));

        tick_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .pre_tick (pre_tick_q),
            .load     (w_load[i]),
            .load_div (lat_div_q),
            .load_en  (lat_en_q),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

    assign cfg.cfg_ready = w_ready;
    assign busy          = ~w_ready;
    assign pre_tick      = pre_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: a cycle model pushes expected outputs per edge,
// the sampler pops and compares them; directed checks cover the timing corners.
`default_nettype none

module tb_tick_scheduler;

    localparam int NCH      = 4;
    localparam int PRESCALE = 50;
    localparam int DIV_W    = 8;
    localparam int CH_W     = 2;

    typedef struct packed {
        logic           pre;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           ready;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           pre_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic           busy;

    tick_scheduler_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg_if ();

    tick_scheduler #(
        .NCH      (NCH),
        .PRESCALE (PRESCALE),
        .DIV_W    (DIV_W),
        .CH_W     (CH_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cfg      (cfg_if),
        .pre_tick (pre_tick),
        .tick     (tick),
        .sq       (sq),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Reference state
    int             m_count;
    bit             m_pre;
    bit             m_pend;
    int             m_lch;
    int             m_ldiv;
    bit             m_len;
    int             m_div[NCH];
    int             m_ph[NCH];
    bit             m_en[NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;

    // Observation counters
    int cyc;
    int first_pre;
    int n_pre;
    int first_t0;
    int t1_prev, t1_last, n_t1;
    int t2_prev, t2_last, n_t2;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_pre   = 1'b0;
        m_pend  = 1'b0;
        m_lch   = 0;
        m_ldiv  = 0;
        m_len   = 1'b0;
        m_tick  = '0;
        m_sq    = '0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 0;
            m_ph[i]  = 0;
            m_en[i]  = 1'b0;
        end
    endtask

    // Advance the reference by one edge using the inputs currently driven.
    task automatic model_edge();
        bit   apply;
        bit   nxt_pre;
        exp_t e;
        apply   = m_pend && m_pre;
        nxt_pre = (m_count == PRESCALE - 1);
        m_count = nxt_pre ? 0 : m_count + 1;
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (apply && (m_lch == i)) begin
                m_div[i] = m_ldiv;
                m_en[i]  = m_len;
                m_ph[i]  = 0;
                if (!m_len) m_sq[i] = 1'b0;
            end else if (m_pre && m_en[i] && (m_div[i] != 0)) begin
                m_ph[i] = m_ph[i] + 1;
                if (m_ph[i] == m_div[i]) begin
                    m_ph[i]   = 0;
                    m_tick[i] = 1'b1;
                    m_sq[i]   = ~m_sq[i];
                end
            end
        end
        if (!m_pend) begin
            if (cfg_if.cfg_valid) begin
                m_lch  = int'(cfg_if.cfg_ch);
                m_ldiv = int'(cfg_if.cfg_div);
                m_len  = cfg_if.cfg_en;
                m_pend = 1'b1;
            end
        end else if (m_pre) begin
            m_pend = 1'b0;
        end
        m_pre   = nxt_pre;
        e.pre   = m_pre;
        e.tick  = m_tick;
        e.sq    = m_sq;
        e.ready = !m_pend;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("pre_tick", 32'(pre_tick), 32'(e.pre));
        chk("tick", 32'(tick), 32'(e.tick));
        chk("sq", 32'(sq), 32'(e.sq));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e.ready));
        chk("busy", 32'(busy), 32'(!e.ready));
        if (pre_tick) begin
            n_pre++;
            if (first_pre < 0) first_pre = cyc;
        end
        if (tick[0] && first_t0 < 0) first_t0 = cyc;
        if (tick[1]) begin
            n_t1++;
            t1_prev = t1_last;
            t1_last = cyc;
        end
        if (tick[2]) begin
            n_t2++;
            t2_prev = t2_last;
            t2_last = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        RST              = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        #2;
        chk("rst_pre_tick", 32'(pre_tick), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        sb.delete();
        @(posedge CLK);
        #1;
        RST       = 1'b1;
        cyc       = 0;
        first_pre = -1;
        n_pre     = 0;
        first_t0  = -1;
    endtask

    task automatic write(input int ch, input int div, input bit en);
        for (int k = 0; k < 200 && m_pend; k++) step();
        if (m_pend) chk("write_wait_idle", 32'd0, 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_div   = DIV_W'(div);
        cfg_if.cfg_en    = en;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int low;
        int k;
        int t2_mark;
        cyc     = 0;
        t1_prev = 0; t1_last = 0; n_t1 = 0;
        t2_prev = 0; t2_last = 0; n_t2 = 0;

        // 1: free-running prescaler, no channel activity
        do_reset();
        run(160);
        chk("t1_first_pre", 32'(first_pre), 32'd50);
        chk("t1_pre_count", 32'(n_pre), 32'd3);

        // 2: ch0 div=1 written at cycle 10, applied at the first strobe
        do_reset();
        run(9);
        write(0, 1, 1'b1);
        chk("t2_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        run(310);
        chk("t2_first_tick0", 32'(first_t0), 32'd101);

        // 3: ch2 div=3 and ch1 div=2 running together
        write(2, 3, 1'b1);
        write(1, 2, 1'b1);
        run(700);
        chk("t3_tick2_period", 32'(t2_last - t2_prev), 32'd150);
        chk("t3_tick1_period", 32'(t1_last - t1_prev), 32'd100);

        // 4: disable ch2 so the apply lands on its due strobe
        for (k = 0; k < 2000; k++) begin
            if (m_ph[2] == 2 && !m_pre && !m_pend && m_count < 30) break;
            step();
        end
        chk("t4_sync", 32'(k < 2000), 32'd1);
        t2_mark = n_t2;
        write(2, 3, 1'b0);
        run(200);
        chk("t4_no_tick2", 32'(n_t2 - t2_mark), 32'd0);
        chk("t4_sq2_low", 32'(sq[2]), 32'd0);

        // 5: request in a strobe cycle waits for the next strobe
        for (k = 0; k < 100; k++) begin
            if (m_pre && !m_pend) break;
            step();
        end
        chk("t5_sync", 32'(k < 100), 32'd1);
        write(3, 1, 1'b1);
        low = cfg_if.cfg_ready ? 0 : 1;
        for (k = 0; k < 100 && !cfg_if.cfg_ready; k++) begin
            step();
            if (!cfg_if.cfg_ready) low++;
        end
        chk("t5_ready_low_cycles", 32'(low), 32'd50);
        run(120);

        // 6: reset while pending discards the write; div=0 stays silent
        write(0, 5, 1'b0);
        run(10);
        do_reset();
        run(120);
        n_t1 = 0;
        write(1, 0, 1'b1);
        run(300);
        chk("t6_div0_silent", 32'(n_t1), 32'd0);
        chk("t6_ready", 32'(cfg_if.cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_scheduler.md
Name:
tick_scheduler

Overview:
- Shared clock-enable scheduler for the Cyclone II core library.
- One free-running prescaler divides CLK by PRESCALE, the same rate as the core's divide-by-50 divider.
- NCH independent channels each count prescaler strobes against a programmable ratio. Each channel emits a one-cycle enable strobe plus a 50%-duty toggle output, used to pace MLP layer sequencing and other slow peripherals.
- A valid/ready config port reprograms one channel at a time. Changes are applied only on a prescaler boundary, so no runt pulses occur.

Parameters:
- NCH, 4, number of channels (2..8).
- PRESCALE, 50, CLK cycles per prescaler strobe (>=2).
- DIV_W, 8, width of the per-channel divide ratio.
- CH_W, 2, width of the channel index; must equal ceil(log2(NCH)).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config port can accept.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  divide ratio in prescaler strobes; 0 is treated as disable.
- cfg_en  in  1  channel enable.
- pre_tick  out  1  prescaler strobe, one CLK cycle wide.
- tick  out  NCH  per-channel enable strobe, one CLK cycle wide.
- sq  out  NCH  per-channel square wave; toggles on each tick.
- busy  out  1  config pending (equals ~cfg_ready).

Behaviour:
- Reset (RST low, async):
  - Prescaler count = 0; pre_tick = 0.
  - All channel counters = 0; div = 0; en = 0.
  - tick = 0; sq = 0.
  - FSM = IDLE; cfg_ready = 1.
- Prescaler:
  - count runs 0..PRESCALE-1 and wraps to 0.
  - pre_tick is registered: high in the cycle after count == PRESCALE-1.
  - After reset release, the first pre_tick is at CLK edge PRESCALE. It then recurs every PRESCALE cycles.
- Channel update (only in cycles where pre_tick == 1, and only if en == 1 and div != 0):
  - If cnt == div-1: cnt <= 0, tick[i] <= 1 for the next cycle, sq[i] <= ~sq[i].
  - Otherwise: cnt <= cnt+1.
- Channel rates:
  - tick period = div*PRESCALE CLK cycles.
  - sq period = 2*div*PRESCALE CLK cycles.
  - div == 1 gives a tick on every pre_tick.
- Disabled channel (en == 0 or div == 0):
  - cnt is held at 0; tick stays 0; sq is held at its current value.
- Config FSM states: IDLE, PEND.
  - IDLE: cfg_ready = 1. When cfg_valid = 1, latch cfg_ch, cfg_div and cfg_en, then go to PEND.
  - PEND: cfg_ready = 0. In the first cycle with pre_tick == 1, apply to channel cfg_ch:
    - div <= latched div; en <= latched en; cnt <= 0.
    - If latched en == 0: sq <= 0.
    - Then return to IDLE; cfg_ready = 1 in the next cycle.
- Boundary: the apply cycle coincides with a pre_tick. The reconfigured channel does not count that pre_tick and produces no tick from it. All other channels count normally.
- Boundary: if cfg_valid arrives in the same cycle as a pre_tick while in IDLE, it is only latched. It is applied at the following pre_tick.
- Boundary: cfg_ch >= NCH is accepted and the write is dropped; it still takes one PEND period.
- Boundary: reprogramming with the same div restarts the channel phase (cnt = 0).
- Boundary: if RST asserts while in PEND, the pending config is discarded.
- Width rules: cnt and div are DIV_W unsigned; div-1 is computed with no underflow because div == 0 is excluded.

Decomposition:
- Package tick_sched_pkg:
  - FSM state enum (IDLE, PEND).
  - Default PRESCALE and DIV_W.
  - A function computing CH_W from NCH.
- Sub-module tick_channel, instantiated NCH times. It holds div, en, cnt and the tick/sq registers. Its inputs are pre_tick, load, load_div, load_en.
- The top level holds the prescaler, the config FSM and the channel-load decode.

Test Plan:
1. Reset release, no config -> pre_tick at CLK edges 50, 100, 150; tick == 0 and sq == 0 throughout.
2. Write ch0 with div=1, en=1 at cycle 10 -> cfg_ready low from cycle 11 until apply at the pre_tick at 50. After that, tick[0] fires the cycle after each later pre_tick (51+50k, first at 101), and sq[0] toggles every 50 cycles.
3. Write ch2 with div=3, en=1, plus ch1 with div=2 -> tick[2] every 150 cycles and tick[1] every 100 cycles. sq[2] period is 300 cycles and sq[1] period is 200 cycles. The phases are independent.
4. Reprogram running ch2 to div=3, en=0 exactly when its tick is due -> no tick is issued at that boundary, sq[2] is forced to 0, and the other channels are unaffected.
5. Assert cfg_valid in a pre_tick cycle -> the write is applied at the next pre_tick (50 cycles later), not the current one. cfg_ready is low for the whole 50 cycles.
6. Drop RST while in PEND -> all outputs return to 0, cfg_ready = 1, and the pending write is never applied. cfg_div=0 with en=1 leaves the channel silent.
